// File: rtl/fp_norm_pack.sv
// fp_norm_pack: back end of the mini-float adder.
// Takes the raw 4-bit magnitude sum and common exponent, normalizes it one
// left shift per cycle, optionally rounds on the guard bit, and packs the
// 6-bit result {sign, exp[2:0], man[1:0]}. Exponent 0 encodes zero.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE,
// and out_word/out_ovf/out_unf stay stable until the edge where out_ready=1.
// Only one operation is in flight; there is no bypass from DONE to accept.
module fp_norm_pack #(
   parameter int ROUND = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       in_s,
   input  logic [2:0] in_e,
   input  logic [3:0] in_m,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [5:0] out_word,
   output logic       out_ovf,
   output logic       out_unf
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_ROUND = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t     state, state_nx;
   logic       s_q, s_nx;
   logic [2:0] e_q, e_nx;
   logic [3:0] m_q, m_nx;
   logic [5:0] word_q, word_nx;
   logic       ovf_q, ovf_nx;
   logic       unf_q, unf_nx;

   // Rounding helpers: r is the kept mantissa, g the guard bit dropped.
   logic [1:0] r_bits;
   logic       g_bit;
   logic [2:0] r_inc;
   logic [2:0] e_inc;
   logic       do_round;

   assign r_bits   = m_q[2:1];
   assign g_bit    = m_q[0];
   assign r_inc    = {1'b0, r_bits} + 3'd1;
   assign e_inc    = e_q + 3'd1;
   assign do_round = (ROUND != 0) && g_bit;

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         s_q    <= 1'b0;
         e_q    <= 3'd0;
         m_q    <= 4'd0;
         word_q <= 6'd0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
      end else begin
         state  <= state_nx;
         s_q    <= s_nx;
         e_q    <= e_nx;
         m_q    <= m_nx;
         word_q <= word_nx;
         ovf_q  <= ovf_nx;
         unf_q  <= unf_nx;
      end
   end

   // Next-state and datapath logic; result fields change only entering DONE.
   always_comb begin
      state_nx = state;
      s_nx     = s_q;
      e_nx     = e_q;
      m_nx     = m_q;
      word_nx  = word_q;
      ovf_nx   = ovf_q;
      unf_nx   = unf_q;
      case (state)
         S_IDLE: begin
            if (in_valid) begin
               s_nx     = in_s;
               e_nx     = in_e;
               m_nx     = in_m;
               state_nx = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (m_q == 4'd0) begin
               // Exact zero: sign is dropped so the word is all zeros.
               word_nx  = 6'd0;
               ovf_nx   = 1'b0;
               unf_nx   = 1'b0;
               state_nx = S_DONE;
            end else if (m_q[3]) begin
               state_nx = S_ROUND;
            end else if (e_q == 3'd1) begin
               // One more shift would land on the reserved zero exponent.
               word_nx  = 6'd0;
               ovf_nx   = 1'b0;
               unf_nx   = 1'b1;
               state_nx = S_DONE;
            end else begin
               m_nx = {m_q[2:0], 1'b0};
               e_nx = e_q - 3'd1;
            end
         end
         S_ROUND: begin
            ovf_nx = 1'b0;
            unf_nx = 1'b0;
            if (!do_round) begin
               word_nx = {s_q, e_q, r_bits};
            end else if (!r_inc[2]) begin
               word_nx = {s_q, e_q, r_inc[1:0]};
            end else if (e_q == 3'd7) begin
               // Mantissa carry would push the exponent past 7: saturate.
               word_nx = {s_q, 3'b111, 2'b11};
               ovf_nx  = 1'b1;
            end else begin
               word_nx = {s_q, e_inc, 2'b00};
            end
            state_nx = S_DONE;
         end
         S_DONE: begin
            if (out_ready) begin
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   assign out_word  = word_q;
   assign out_ovf   = ovf_q;
   assign out_unf   = unf_q;

endmodule
